// File: rtl/next_queue_pkg.sv
// Shared types and sizing for the NEXT instruction queue.
// NEXT_DEPTH is also consumed by the issue-stage stall logic.
package next_queue_pkg;

    localparam int unsigned ROB_WIDTH  = 6;
    localparam int unsigned GC_WIDTH   = 16;
    localparam int unsigned N_B_ENTRY  = 4;
    localparam int unsigned BC_WIDTH   = $clog2(N_B_ENTRY) + 1;
    localparam int unsigned NEXT_DEPTH = 4;

    typedef struct packed {
        logic                 valid;
        logic [ROB_WIDTH-1:0] tag;
        logic [BC_WIDTH-1:0]  b_count;
    } next_entry_t;

    // Outstanding-branch count after this cycle's commit; saturates at zero
    function automatic logic [BC_WIDTH-1:0] b_update(input logic [BC_WIDTH-1:0] b_count,
                                                     input logic                b_commit);
        return (b_count == '0) ? '0 : b_count - BC_WIDTH'(b_commit);
    endfunction

endpackage

// File: rtl/next_confirm_scan.sv
// Length of the run of valid, confirmed (b_count == 0) entries starting at head.
// Used to place the tail after a misprediction flush.
module next_confirm_scan
    import next_queue_pkg::*;
#(
    parameter int unsigned DEPTH = NEXT_DEPTH
) (
    input  next_entry_t [DEPTH-1:0]       entries,
    input  logic [$clog2(DEPTH)-1:0]      head,
    output logic [$clog2(DEPTH+1)-1:0]    confirmed
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] idx;
    logic             in_prefix;

    // Walk from head in queue order; stop counting at the first unconfirmed slot
    always_comb begin
        confirmed = '0;
        in_prefix = 1'b1;
        idx       = head;
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = head + PTR_W'(i);
            if (in_prefix && entries[idx].valid && (entries[idx].b_count == '0)) begin
                confirmed = confirmed + CNT_W'(1);
            end else begin
                in_prefix = 1'b0;
            end
        end
    end

endmodule

// File: rtl/next_queue.sv
// In-order queue of NEXT instructions. The head dispatches once its branch
// count reaches zero: it reads/advances the GC and drives the GPR CDB.
// Optional feature: define NEXT_BYPASS_EN to let an issue into an empty queue
// dispatch in its issue cycle.
module next_queue
    import next_queue_pkg::*;
#(
    parameter int unsigned DEPTH     = NEXT_DEPTH,
    parameter int unsigned RES_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         issue_req_valid,
    output logic                         issue_req_ready,
    input  logic [ROB_WIDTH-1:0]         gpr_issue_tag,
    input  logic [BC_WIDTH-1:0]          b_count_next,
    input  logic                         b_commit,
    input  logic                         failure,
    output logic                         gc_req_valid,
    input  logic                         gc_req_ready,
    input  logic [GC_WIDTH-1:0]          gc,
    output logic                         gpr_cdb_req_valid,
    input  logic                         gpr_cdb_req_ready,
    output logic [ROB_WIDTH-1:0]         tag,
    output logic [RES_WIDTH-1:0]         result,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    next_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic [PTR_W-1:0]        head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [BC_WIDTH-1:0]     b_upd [DEPTH];
    logic [CNT_W-1:0]        confirmed;
    logic                    full, head_ok, bypass, dispatch, issue_acc, push, pop;

    next_confirm_scan #(
        .DEPTH     (DEPTH)
    ) u_confirm_scan (
        .entries   (entries_q),
        .head      (head_q),
        .confirmed (confirmed)
    );

    // Branch counts as they will be after this cycle's commit
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            b_upd[i] = b_update(entries_q[i].b_count, b_commit);
        end
    end

    assign full    = (count_q == CNT_W'(DEPTH));
    assign head_ok = entries_q[head_q].valid && (b_upd[head_q] == '0);

`ifdef NEXT_BYPASS_EN
    assign bypass = (count_q == '0) && issue_req_valid && (b_count_next == '0);
`else
    assign bypass = 1'b0;
`endif

    // Handshake and dispatch outputs, all combinational in the dispatch cycle
    always_comb begin
        gc_req_valid      = (head_ok || bypass) && gpr_cdb_req_ready && !failure;
        dispatch          = gc_req_valid && gc_req_ready;
        gpr_cdb_req_valid = dispatch;
        tag               = (head_ok || !bypass) ? entries_q[head_q].tag : gpr_issue_tag;
        result            = RES_WIDTH'($signed(gc));
`ifdef NEXT_BYPASS_EN
        // A full queue whose head leaves this cycle can take the issue into the freed slot
        issue_req_ready   = !full || dispatch;
`else
        issue_req_ready   = !full;
`endif
        issue_acc         = issue_req_valid && issue_req_ready && !failure;
        pop               = dispatch && head_ok;
        // A bypassed issue is consumed by its own dispatch and never stored
        push              = issue_acc && !(dispatch && !head_ok);
        occupancy         = count_q;
    end

    // Next-state: flush, branch-count update, pop at head, push at tail
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (failure) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (entries_q[i].b_count != '0) begin
                    entries_d[i].valid = 1'b0;
                end
            end
            tail_d  = head_q + PTR_W'(confirmed);
            count_d = confirmed;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_d[i].b_count = b_upd[i];
            end
            if (pop) begin
                entries_d[head_q].valid = 1'b0;
                head_d                  = head_q + PTR_W'(1);
            end
            if (push) begin
                entries_d[tail_q].valid   = 1'b1;
                entries_d[tail_q].tag     = gpr_issue_tag;
                entries_d[tail_q].b_count = b_count_next;
                tail_d                    = tail_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State registers; reset empties the queue immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

endmodule
